// File: rtl/serial_frame_receiver_if.sv
// Handshake and status bundle between a serial frame receiver and its consumer.
interface serial_frame_receiver_if #(
    parameter int unsigned DATA_W = 4
);
    logic              Rx;
    logic              Ready;
    logic [DATA_W-1:0] ParalelOutput;
    logic              Valid;
    logic              ParityError;
    logic              FrameError;
    logic              Overrun;
    logic              Busy;

    modport master (
        output Rx, Ready,
        input  ParalelOutput, Valid, ParityError, FrameError, Overrun, Busy
    );

    modport slave (
        input  Rx, Ready,
        output ParalelOutput, Valid, ParityError, FrameError, Overrun, Busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Receives idle-high start/data/parity/stop frames, LSB first, and presents each good
// word behind a Valid/Ready handshake with parity, framing and overrun flags.
module serial_frame_receiver #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input logic                    Clk,
    input logic                    Reset,
    serial_frame_receiver_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] HalfM1  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullM1  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              valid_q, valid_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              ovr_q, ovr_d;
    logic              rx_meta_q, rxs_q;
    logic              load;

    // Synchronizer resets to the idle line level so reset release never looks like a start.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.Rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        ovr_d   = 1'b0;
        load    = 1'b0;

        if (valid_q && bus.Ready) valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = StStart;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FullM1) begin
                    cnt_d               = '0;
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = rxs_q;
                    bit_d               = bit_q + 1'b1;
                    if (bit_q == LastBit) state_d = (PARITY_EN != 0) ? StParity : StStop;
                end
            end
            StParity: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    perr_d  = rxs_q ^ (^shift_q);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == FullM1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = StIdle;
                        if (perr_q) pe_d = 1'b1;
                        else        load = 1'b1;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A load coinciding with a consume keeps Valid high without flagging overrun.
        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !bus.Ready;
        end
    end

    assign bus.ParalelOutput = data_q;
    assign bus.Valid         = valid_q;
    assign bus.ParityError   = pe_q;
    assign bus.FrameError    = fe_q;
    assign bus.Overrun       = ovr_q;
    assign bus.Busy          = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with default parameters (4 data bits, 4 clk/bit,
// even parity).
module tb_serial_frame_receiver;

    localparam int unsigned C = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_frame_receiver_if #(.DATA_W(4)) bus ();

    serial_frame_receiver #(
        .DATA_W      (4),
        .CLKS_PER_BIT(C),
        .PARITY_EN   (1)
    ) dut (
        .Clk  (clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.Rx = b;
        repeat (C) tick();
    endtask

    task automatic send_body(input logic [3:0] d, input logic par, input logic stop);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        send_body(d, par, stop);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pe"}, {31'd0, bus.ParityError}, 32'd0);
        check({tag, "_fe"}, {31'd0, bus.FrameError}, 32'd0);
        check({tag, "_ovr"}, {31'd0, bus.Overrun}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.Rx    = 1'b1;
        bus.Ready = 1'b0;
        #2;
        check("rst_valid", {31'd0, bus.Valid}, 32'd0);
        check("rst_data", {28'd0, bus.ParalelOutput}, 32'h0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check_quiet("rst");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", {31'd0, bus.Busy}, 32'd0);

        // Good frame 1010: Valid at t0+26, i.e. 29 edges after the start bit is driven.
        send_frame(4'b1010, 1'b0, 1'b1);
        check("t1_not_yet", {31'd0, bus.Valid}, 32'd0);
        tick();
        check("t1_valid", {31'd0, bus.Valid}, 32'd1);
        check("t1_data", {28'd0, bus.ParalelOutput}, 32'ha);
        check_quiet("t1");
        tick();
        check("t1_hold", {31'd0, bus.Valid}, 32'd1);
        bus.Ready = 1'b1;
        tick();
        check("t1_consumed", {31'd0, bus.Valid}, 32'd0);
        bus.Ready = 1'b0;
        repeat (4) tick();

        // Bad parity on 0111.
        send_frame(4'b0111, 1'b0, 1'b1);
        tick();
        check("t2_pe", {31'd0, bus.ParityError}, 32'd1);
        check("t2_valid", {31'd0, bus.Valid}, 32'd0);
        check("t2_data", {28'd0, bus.ParalelOutput}, 32'ha);
        tick();
        check("t2_pe_width", {31'd0, bus.ParityError}, 32'd0);
        repeat (4) tick();

        // Framing error then a break held low.
        send_frame(4'b0011, 1'b0, 1'b0);
        tick();
        check("t3_fe", {31'd0, bus.FrameError}, 32'd1);
        check("t3_no_pe", {31'd0, bus.ParityError}, 32'd0);
        tick();
        check("t3_fe_width", {31'd0, bus.FrameError}, 32'd0);
        repeat (40) tick();
        check("t3_busy_break", {31'd0, bus.Busy}, 32'd1);
        bus.Rx = 1'b1;
        tick();
        tick();
        check("t3_busy_sync", {31'd0, bus.Busy}, 32'd1);
        tick();
        check("t3_idle", {31'd0, bus.Busy}, 32'd0);
        repeat (10) tick();
        check("t3_valid", {31'd0, bus.Valid}, 32'd0);
        check("t3_data", {28'd0, bus.ParalelOutput}, 32'ha);
        check_quiet("t3");

        // One-cycle glitch: START rejects it two edges after t0.
        bus.Rx = 1'b0;
        tick();
        bus.Rx = 1'b1;
        repeat (3) tick();
        check("t4_busy_start", {31'd0, bus.Busy}, 32'd1);
        tick();
        check("t4_back_idle", {31'd0, bus.Busy}, 32'd0);
        repeat (6) tick();
        check("t4_valid", {31'd0, bus.Valid}, 32'd0);
        check_quiet("t4");

        // Back-to-back frames with Ready low: second load overruns.
        send_frame(4'b0001, 1'b1, 1'b1);
        bus.Rx = 1'b0;
        tick();
        check("t5_first_valid", {31'd0, bus.Valid}, 32'd1);
        check("t5_first_data", {28'd0, bus.ParalelOutput}, 32'h1);
        check("t5_first_ovr", {31'd0, bus.Overrun}, 32'd0);
        repeat (C - 1) tick();
        send_body(4'b1110, 1'b1, 1'b1);
        tick();
        check("t5_ovr", {31'd0, bus.Overrun}, 32'd1);
        check("t5_valid", {31'd0, bus.Valid}, 32'd1);
        check("t5_data", {28'd0, bus.ParalelOutput}, 32'he);
        tick();
        check("t5_ovr_width", {31'd0, bus.Overrun}, 32'd0);

        // Load on the same edge as a consume: no overrun.
        send_frame(4'b0001, 1'b1, 1'b1);
        bus.Ready = 1'b1;
        tick();
        bus.Ready = 1'b0;
        check("t5b_valid", {31'd0, bus.Valid}, 32'd1);
        check("t5b_data", {28'd0, bus.ParalelOutput}, 32'h1);
        check("t5b_no_ovr", {31'd0, bus.Overrun}, 32'd0);
        repeat (4) tick();

        // Reset during data bit 2 of 1100.
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        bus.Rx = 1'b1;
        tick();
        tick();
        check("t6_busy_pre", {31'd0, bus.Busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, bus.Valid}, 32'd0);
        check("t6_rst_data", {28'd0, bus.ParalelOutput}, 32'h0);
        check("t6_rst_busy", {31'd0, bus.Busy}, 32'd0);
        check_quiet("t6_rst");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("t6_post_valid", {31'd0, bus.Valid}, 32'd0);
        check("t6_post_busy", {31'd0, bus.Busy}, 32'd0);
        send_frame(4'b0101, 1'b0, 1'b1);
        check("t6_not_yet", {31'd0, bus.Valid}, 32'd0);
        tick();
        check("t6_valid", {31'd0, bus.Valid}, 32'd1);
        check("t6_data", {28'd0, bus.ParalelOutput}, 32'h5);
        check_quiet("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
